// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM.
// Drives datapath selects/enables, stalls on mem_ready, counts retires.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        EXTOp,
  output logic [3:0]  ALUOp,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;

  state_t cur, nxt;

  logic is_r;
  logic i_add, i_sub, i_and, i_or, i_slt, i_jr;
  logic i_addi, i_ori, i_lw, i_sw;
  logic i_beq, i_bne, i_j, i_jal;
  logic r_alu, legal, retire;
  logic [3:0] r_fn;

  assign is_r   = Op == 6'b000000;
  assign i_add  = is_r && Funct == 6'b100000;
  assign i_sub  = is_r && Funct == 6'b100010;
  assign i_and  = is_r && Funct == 6'b100100;
  assign i_or   = is_r && Funct == 6'b100101;
  assign i_slt  = is_r && Funct == 6'b101010;
  assign i_jr   = is_r && Funct == 6'b001000;
  assign i_addi = Op == 6'b001000;
  assign i_ori  = Op == 6'b001101;
  assign i_lw   = Op == 6'b100011;
  assign i_sw   = Op == 6'b101011;
  assign i_beq  = Op == 6'b000100;
  assign i_bne  = Op == 6'b000101;
  assign i_j    = Op == 6'b000010;
  assign i_jal  = Op == 6'b000011;

  assign r_alu = i_add | i_sub | i_and | i_or | i_slt;
  assign legal = r_alu | i_jr | i_addi | i_ori | i_lw | i_sw
               | i_beq | i_bne | i_j | i_jal;

  always_comb begin
    r_fn = ALU_ADD;
    unique case (1'b1)
      i_sub:   r_fn = ALU_SUB;
      i_and:   r_fn = ALU_AND;
      i_or:    r_fn = ALU_OR;
      i_slt:   r_fn = ALU_SLT;
      default: r_fn = ALU_ADD;
    endcase
  end

  always_comb begin
    nxt      = cur;
    PCWrite  = 1'b0;
    PCSrc    = 2'b00;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 2'b00;
    MemtoReg = 2'b00;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    EXTOp    = 1'b0;
    ALUOp    = 4'd0;
    unique case (cur)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        EXTOp   = 1'b1;
        ALUOp   = ALU_ADD;
        nxt     = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        unique case (1'b1)
          r_alu: begin
            ALUSrcA = 1'b1;
            ALUOp   = r_fn;
            nxt     = S_WB;
          end
          i_addi: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            EXTOp   = 1'b1;
            ALUOp   = ALU_ADD;
            nxt     = S_WB;
          end
          i_ori: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = ALU_OR;
            nxt     = S_WB;
          end
          i_lw, i_sw: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            EXTOp   = 1'b1;
            ALUOp   = ALU_ADD;
            nxt     = S_MEM;
          end
          i_beq, i_bne: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_SUB;
            PCSrc   = 2'b01;
            PCWrite = i_beq ? Zero : ~Zero;
            nxt     = S_FETCH;
          end
          i_j: begin
            PCWrite = 1'b1;
            PCSrc   = 2'b10;
            nxt     = S_FETCH;
          end
          i_jal: begin
            PCWrite  = 1'b1;
            PCSrc    = 2'b10;
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
            nxt      = S_FETCH;
          end
          i_jr: begin
            PCWrite = 1'b1;
            PCSrc   = 2'b11;
            nxt     = S_FETCH;
          end
          default: nxt = S_TRAP;
        endcase
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemWrite = i_sw;
        MemRead  = ~i_sw;
        if (mem_ready)
          nxt = i_sw ? S_FETCH : S_WB;
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = is_r ? 2'b01 : 2'b00;
        MemtoReg = i_lw ? 2'b01 : 2'b00;
        nxt      = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
    // reset wins over any state, even mid-access
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign retire = (cur == S_EXEC || cur == S_MEM || cur == S_WB)
               && nxt == S_FETCH;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_FETCH;
      illegal <= 1'b0;
      instret <= 32'd0;
    end else begin
      cur <= nxt;
      if (nxt == S_TRAP)
        illegal <= 1'b1;
      if (retire)
        instret <= instret + 32'd1;
    end
  end

  assign state = cur;

endmodule
